// File: rtl/frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : frame_sequencer
// Brief    : Replays a valid/ready pixel source as a blanked raster stream.
// Revision : 1.0 - initial release
// ============================================================================
module frame_sequencer #(
  parameter int HBLANK = 4,
  parameter int VBLANK = 16
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Start,
  input  logic       Continuous,
  input  logic [7:0] CfgWidth,
  input  logic [7:0] CfgHeight,
  input  logic [7:0] SrcPixel,
  input  logic       SrcValid,
  output logic       SrcReady,
  output logic [7:0] PixelOut,
  output logic       PixelValid,
  output logic       FrameOut,
  output logic       LineOut,
  output logic [7:0] Width,
  output logic [7:0] Height,
  output logic       Busy,
  output logic       Done,
  output logic       Underrun
);

  localparam int c_BMAX = (HBLANK > VBLANK) ? HBLANK : VBLANK;
  localparam int c_BW   = $clog2(c_BMAX + 1);
  localparam logic [c_BW-1:0] c_HB_LAST = c_BW'(HBLANK - 1);
  localparam logic [c_BW-1:0] c_VB_LAST = c_BW'(VBLANK - 1);
  localparam bit c_NO_HB = (HBLANK == 0);

  localparam logic [1:0] c_S_IDLE   = 2'd0;
  localparam logic [1:0] c_S_ACTIVE = 2'd1;
  localparam logic [1:0] c_S_HBLANK = 2'd2;
  localparam logic [1:0] c_S_VBLANK = 2'd3;

  logic [1:0]      r_state;
  logic [1:0]      w_next;
  logic [7:0]      r_col;
  logic [7:0]      r_row;
  logic [c_BW-1:0] r_blank;
  logic [7:0]      r_width;
  logic [7:0]      r_height;
  logic [7:0]      r_pix;
  logic            r_pv;
  logic            r_fo;
  logic            r_lo;
  logic            r_done;
  logic            r_ur;

  logic w_cfg_ok;
  logic w_last_col;
  logic w_last_row;
  logic w_hb_end;
  logic w_vb_end;
  logic w_in_blank;
  logic w_launch;
  logic w_row_adv;

  assign w_cfg_ok   = (CfgWidth != 8'd0) && (CfgHeight != 8'd0);
  assign w_last_col = (r_col == r_width - 8'd1);
  assign w_last_row = (r_row == r_height - 8'd1);
  assign w_hb_end   = (r_blank == c_HB_LAST);
  assign w_vb_end   = (r_blank == c_VB_LAST);
  assign w_in_blank = (r_state == c_S_HBLANK) || (r_state == c_S_VBLANK);

  // A frame launches from IDLE on Start, or back-to-back at the end of VBLANK.
  assign w_launch = ((r_state == c_S_IDLE) && Start && w_cfg_ok) ||
                    ((r_state == c_S_VBLANK) && w_vb_end && Continuous && w_cfg_ok);

  assign w_row_adv = ((r_state == c_S_ACTIVE) && w_last_col && !w_last_row && c_NO_HB) ||
                     ((r_state == c_S_HBLANK) && w_hb_end);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= c_S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_S_IDLE: begin
        if (Start && w_cfg_ok) w_next = c_S_ACTIVE;
      end
      c_S_ACTIVE: begin
        if (w_last_col) begin
          if (w_last_row)    w_next = c_S_VBLANK;
          else if (!c_NO_HB) w_next = c_S_HBLANK;
        end
      end
      c_S_HBLANK: begin
        if (w_hb_end) w_next = c_S_ACTIVE;
      end
      c_S_VBLANK: begin
        if (w_vb_end) w_next = (Continuous && w_cfg_ok) ? c_S_ACTIVE : c_S_IDLE;
      end
      default: w_next = c_S_IDLE;
    endcase
  end

  always_comb begin
    SrcReady = (r_state == c_S_ACTIVE);
    Busy     = (r_state != c_S_IDLE);
  end

  // Every ACTIVE slot emits a pixel; a missing source pixel becomes zero.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_col    <= 8'd0;
      r_row    <= 8'd0;
      r_blank  <= '0;
      r_width  <= 8'd0;
      r_height <= 8'd0;
      r_pix    <= 8'd0;
      r_pv     <= 1'b0;
      r_fo     <= 1'b0;
      r_lo     <= 1'b0;
      r_done   <= 1'b0;
      r_ur     <= 1'b0;
    end else begin
      r_pix  <= 8'd0;
      r_pv   <= 1'b0;
      r_fo   <= 1'b0;
      r_lo   <= 1'b0;
      r_done <= (r_state == c_S_VBLANK) && w_vb_end;

      if (r_state == c_S_ACTIVE) begin
        r_pv  <= 1'b1;
        r_pix <= SrcValid ? SrcPixel : 8'd0;
        r_fo  <= (r_col == 8'd0) && (r_row == 8'd0);
        r_lo  <= (r_col == 8'd0) && (r_row != 8'd0);
        r_col <= w_last_col ? 8'd0 : r_col + 8'd1;
        if (!SrcValid) r_ur <= 1'b1;
      end

      r_blank <= (w_in_blank && (w_next == r_state)) ? r_blank + c_BW'(1) : '0;

      if (w_row_adv) r_row <= r_row + 8'd1;

      if (w_launch) begin
        r_width  <= CfgWidth;
        r_height <= CfgHeight;
        r_col    <= 8'd0;
        r_row    <= 8'd0;
        if (r_state == c_S_IDLE) r_ur <= 1'b0;
      end
    end
  end

  assign PixelOut   = r_pix;
  assign PixelValid = r_pv;
  assign FrameOut   = r_fo;
  assign LineOut    = r_lo;
  assign Width      = r_width;
  assign Height     = r_height;
  assign Done       = r_done;
  assign Underrun   = r_ur;

endmodule
`default_nettype wire

// File: tb/tb_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_frame_sequencer
// Brief    : Directed vector bench for frame_sequencer (4x3, HBLANK=2, VBLANK=3).
// Revision : 1.0 - initial release
// ============================================================================
module tb_frame_sequencer;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       Start;
  logic       Continuous;
  logic [7:0] CfgWidth;
  logic [7:0] CfgHeight;
  logic [7:0] SrcPixel;
  logic       SrcValid;
  logic       SrcReady;
  logic [7:0] PixelOut;
  logic       PixelValid;
  logic       FrameOut;
  logic       LineOut;
  logic [7:0] Width;
  logic [7:0] Height;
  logic       Busy;
  logic       Done;
  logic       Underrun;

  frame_sequencer #(.HBLANK(2), .VBLANK(3)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Start      (Start),
    .Continuous (Continuous),
    .CfgWidth   (CfgWidth),
    .CfgHeight  (CfgHeight),
    .SrcPixel   (SrcPixel),
    .SrcValid   (SrcValid),
    .SrcReady   (SrcReady),
    .PixelOut   (PixelOut),
    .PixelValid (PixelValid),
    .FrameOut   (FrameOut),
    .LineOut    (LineOut),
    .Width      (Width),
    .Height     (Height),
    .Busy       (Busy),
    .Done       (Done),
    .Underrun   (Underrun)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    int scen; int cyc;
    int rdy; int pv; int fo; int lo; int px;
    int busy; int done; int ur; int wid; int cpx;
  } vec_t;

  vec_t tbl[80];
  int   ntbl     = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   next_pix = 1;

  function automatic void add(input int s, c, rdy, pv, fo, lo, px, busy, done, ur, wid, cpx);
    tbl[ntbl] = '{s, c, rdy, pv, fo, lo, px, busy, done, ur, wid, cpx};
    ntbl++;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic check_cycle(input int s, input int c);
    string p;
    for (int i = 0; i < ntbl; i++) begin
      if (tbl[i].scen == s && tbl[i].cyc == c) begin
        p = $sformatf("s%0d c%0d", s, c);
        chk({p, " SrcReady"},   int'(SrcReady),   tbl[i].rdy);
        chk({p, " PixelValid"}, int'(PixelValid), tbl[i].pv);
        chk({p, " FrameOut"},   int'(FrameOut),   tbl[i].fo);
        chk({p, " LineOut"},    int'(LineOut),    tbl[i].lo);
        chk({p, " Busy"},       int'(Busy),       tbl[i].busy);
        chk({p, " Done"},       int'(Done),       tbl[i].done);
        chk({p, " Underrun"},   int'(Underrun),   tbl[i].ur);
        chk({p, " Width"},      int'(Width),      tbl[i].wid);
        if (tbl[i].cpx != 0) chk({p, " PixelOut"}, int'(PixelOut), tbl[i].px);
      end
    end
  endtask

  // Source model: the pixel counter advances only on an accepted transfer.
  task automatic tick();
    logic xfer;
    xfer = SrcValid && SrcReady;
    @(posedge Clk);
    #1;
    if (xfer) next_pix++;
  endtask

  task automatic run_scen(input int s, input int ncyc);
    next_pix = 1;
    for (int c = 0; c < ncyc; c++) begin
      Start      = (c == 0) || (s == 4 && (c == 3 || c == 10 || c == 19));
      SrcValid   = !(s == 2 && c == 15);
      Continuous = (s == 3 && c < 25);
      Reset      = (s == 5 && c == 9);
      if (s == 3 && c == 5) CfgWidth = 8'd2;
      SrcPixel   = 8'(next_pix);
      check_cycle(s, c);
      tick();
    end
    Start = 1'b0;
    Reset = 1'b0;
  endtask

  task automatic check_reset_zero(input int k);
    string p;
    p = $sformatf("reset%0d", k);
    chk({p, " SrcReady"},   int'(SrcReady),   0);
    chk({p, " PixelOut"},   int'(PixelOut),   0);
    chk({p, " PixelValid"}, int'(PixelValid), 0);
    chk({p, " FrameOut"},   int'(FrameOut),   0);
    chk({p, " LineOut"},    int'(LineOut),    0);
    chk({p, " Width"},      int'(Width),      0);
    chk({p, " Height"},     int'(Height),     0);
    chk({p, " Busy"},       int'(Busy),       0);
    chk({p, " Done"},       int'(Done),       0);
    chk({p, " Underrun"},   int'(Underrun),   0);
  endtask

  initial begin
    // scen, cyc, rdy, pv, fo, lo, px, busy, done, ur, wid, cpx
    add(1, 0, 0,0,0,0,0,  0,0,0,0, 0);
    add(1, 1, 1,0,0,0,0,  1,0,0,4, 0);
    add(1, 2, 1,1,1,0,1,  1,0,0,4, 1);
    add(1, 5, 0,1,0,0,4,  1,0,0,4, 1);
    add(1, 6, 0,0,0,0,0,  1,0,0,4, 0);
    add(1, 7, 1,0,0,0,0,  1,0,0,4, 0);
    add(1, 8, 1,1,0,1,5,  1,0,0,4, 1);
    add(1,14, 1,1,0,1,9,  1,0,0,4, 1);
    add(1,17, 0,1,0,0,12, 1,0,0,4, 1);
    add(1,18, 0,0,0,0,0,  1,0,0,4, 0);
    add(1,19, 0,0,0,0,0,  1,0,0,4, 0);
    add(1,20, 0,0,0,0,0,  0,1,0,4, 0);
    add(1,21, 0,0,0,0,0,  0,0,0,4, 0);
    // underrun in cycle 15
    add(2, 0, 0,0,0,0,0,  0,0,0,4, 0);
    add(2,14, 1,1,0,1,9,  1,0,0,4, 1);
    add(2,15, 1,1,0,0,10, 1,0,0,4, 1);
    add(2,16, 1,1,0,0,0,  1,0,1,4, 1);
    add(2,17, 0,1,0,0,11, 1,0,1,4, 1);
    add(2,20, 0,0,0,0,0,  0,1,1,4, 0);
    // continuous, width changed to 2 mid-frame
    add(3, 0, 0,0,0,0,0,  0,0,1,4, 0);
    add(3, 1, 1,0,0,0,0,  1,0,0,4, 0);
    add(3, 2, 1,1,1,0,1,  1,0,0,4, 1);
    add(3,19, 0,0,0,0,0,  1,0,0,4, 0);
    add(3,20, 1,0,0,0,0,  1,1,0,2, 0);
    add(3,21, 1,1,1,0,13, 1,0,0,2, 1);
    add(3,22, 0,1,0,0,14, 1,0,0,2, 1);
    add(3,25, 1,1,0,1,15, 1,0,0,2, 1);
    add(3,29, 1,1,0,1,17, 1,0,0,2, 1);
    add(3,30, 0,1,0,0,18, 1,0,0,2, 1);
    add(3,32, 0,0,0,0,0,  1,0,0,2, 0);
    add(3,33, 0,0,0,0,0,  0,1,0,2, 0);
    add(3,34, 0,0,0,0,0,  0,0,0,2, 0);
    // Start with zero height is ignored
    add(6, 1, 0,0,0,0,0,  0,0,0,2, 0);
    add(6, 2, 0,0,0,0,0,  0,0,0,2, 0);
    add(6, 3, 0,0,0,0,0,  0,0,0,2, 0);
    // stray Start pulses mid-frame
    add(4, 1, 1,0,0,0,0,  1,0,0,4, 0);
    add(4, 2, 1,1,1,0,1,  1,0,0,4, 1);
    add(4, 4, 1,1,0,0,3,  1,0,0,4, 1);
    add(4, 8, 1,1,0,1,5,  1,0,0,4, 1);
    add(4,17, 0,1,0,0,12, 1,0,0,4, 1);
    add(4,20, 0,0,0,0,0,  0,1,0,4, 0);
    add(4,21, 0,0,0,0,0,  0,0,0,4, 0);
    add(4,22, 0,0,0,0,0,  0,0,0,4, 0);
    // reset at row 1, col 2
    add(5, 8, 1,1,0,1,5,  1,0,0,4, 1);
    add(5, 9, 1,1,0,0,6,  1,0,0,4, 1);
    add(5,10, 0,0,0,0,0,  0,0,0,0, 1);
    add(5,11, 0,0,0,0,0,  0,0,0,0, 1);
    add(5,20, 0,0,0,0,0,  0,0,0,0, 0);
    add(5,24, 0,0,0,0,0,  0,0,0,0, 0);

    Reset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      Start      = 1'($urandom);
      Continuous = 1'($urandom);
      CfgWidth   = 8'($urandom);
      CfgHeight  = 8'($urandom);
      SrcPixel   = 8'($urandom);
      SrcValid   = 1'($urandom);
      @(posedge Clk);
      #1;
      check_reset_zero(k);
    end
    Reset      = 1'b0;
    Start      = 1'b0;
    Continuous = 1'b0;
    CfgWidth   = 8'd4;
    CfgHeight  = 8'd3;
    SrcValid   = 1'b1;
    SrcPixel   = 8'd0;
    tick();

    run_scen(1, 22);
    run_scen(2, 21);
    run_scen(3, 35);
    CfgWidth  = 8'd4;
    CfgHeight = 8'd0;
    run_scen(6, 4);
    CfgHeight = 8'd3;
    run_scen(4, 23);
    run_scen(5, 25);
    run_scen(1, 22);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
